// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register of the 32-bit RISC-V core.
// It registers decoded operands and control and drives the ALU operands.
// It also raises a load-use hazard request that inserts one bubble.
// Optional feature macro: FORWARDING_EN.
//   Defined:   MEM->EX and WB->EX operand forwarding are enabled.
//   Undefined: no forwarding. Any RAW dependency on EX, MEM or WB raises
//              the hazard.
module id_ex_stage #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            stall,
    input  logic            flush,
    input  logic            in_valid,
    input  logic [XLEN-1:0] in_rs1_data,
    input  logic [XLEN-1:0] in_rs2_data,
    input  logic [XLEN-1:0] in_imm,
    input  logic [4:0]      in_rs1_addr,
    input  logic [4:0]      in_rs2_addr,
    input  logic [4:0]      in_rd_addr,
    input  logic            in_alu_src,
    input  logic [2:0]      in_alu_control,
    input  logic            in_reg_write,
    input  logic            in_mem_read,
    input  logic            in_mem_write,
    input  logic [4:0]      mem_rd_addr,
    input  logic [4:0]      wb_rd_addr,
    input  logic            mem_reg_write,
    input  logic            wb_reg_write,
    input  logic [XLEN-1:0] mem_result,
    input  logic [XLEN-1:0] wb_result,
    output logic [XLEN-1:0] alu_a,
    output logic [XLEN-1:0] alu_b,
    output logic [2:0]      alu_control,
    output logic            ex_valid,
    output logic            ex_reg_write,
    output logic            ex_mem_read,
    output logic            ex_mem_write,
    output logic [4:0]      ex_rd_addr,
    output logic [XLEN-1:0] ex_store_data,
    output logic            load_use_hazard
);

    // One packed record holds the whole stage, so a bubble is simply all zeros.
    typedef struct packed {
        logic            valid;
        logic            reg_write;
        logic            mem_read;
        logic            mem_write;
        logic            alu_src;
        logic [2:0]      alu_control;
        logic [4:0]      rd_addr;
        logic [4:0]      rs1_addr;
        logic [4:0]      rs2_addr;
        logic [XLEN-1:0] rs1_data;
        logic [XLEN-1:0] rs2_data;
        logic [XLEN-1:0] imm;
    } stage_t;

    stage_t          stage_q;
    stage_t          stage_d;
    logic [XLEN-1:0] fwd_rs1;
    logic [XLEN-1:0] fwd_rs2;
    logic            load_use_raw;

    // Build the capture value. An empty decode slot is gated to a bubble.
    always_comb begin
        stage_d = '0;
        if (in_valid) begin
            stage_d.valid       = 1'b1;
            stage_d.reg_write   = in_reg_write;
            stage_d.mem_read    = in_mem_read;
            stage_d.mem_write   = in_mem_write;
            stage_d.alu_src     = in_alu_src;
            stage_d.alu_control = in_alu_control;
            stage_d.rd_addr     = in_rd_addr;
            stage_d.rs1_addr    = in_rs1_addr;
            stage_d.rs2_addr    = in_rs2_addr;
            stage_d.rs1_data    = in_rs1_data;
            stage_d.rs2_data    = in_rs2_data;
            stage_d.imm         = in_imm;
        end
    end

    // Stage register. Priority: flush bubble, then stall hold, then hazard bubble, then capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage_q <= '0;
        end else if (flush) begin
            stage_q <= '0;
        end else if (stall) begin
            stage_q <= stage_q;
        end else if (load_use_hazard) begin
            stage_q <= '0;
        end else begin
            stage_q <= stage_d;
        end
    end

    // Classic load-use check against the instruction currently in EX.
    // It deliberately ignores whether rs2 is really used.
    assign load_use_raw = stage_q.valid && stage_q.mem_read && (stage_q.rd_addr != 5'd0) &&
                          in_valid &&
                          ((stage_q.rd_addr == in_rs1_addr) || (stage_q.rd_addr == in_rs2_addr));

`ifdef FORWARDING_EN
    // Operand forwarding. MEM wins over WB, and x0 is never forwarded.
    always_comb begin
        fwd_rs1 = stage_q.rs1_data;
        fwd_rs2 = stage_q.rs2_data;
        if (mem_reg_write && (mem_rd_addr != 5'd0) && (mem_rd_addr == stage_q.rs1_addr)) begin
            fwd_rs1 = mem_result;
        end else if (wb_reg_write && (wb_rd_addr != 5'd0) && (wb_rd_addr == stage_q.rs1_addr)) begin
            fwd_rs1 = wb_result;
        end
        if (mem_reg_write && (mem_rd_addr != 5'd0) && (mem_rd_addr == stage_q.rs2_addr)) begin
            fwd_rs2 = mem_result;
        end else if (wb_reg_write && (wb_rd_addr != 5'd0) && (wb_rd_addr == stage_q.rs2_addr)) begin
            fwd_rs2 = wb_result;
        end
    end

    assign load_use_hazard = load_use_raw;
`else
    logic raw_rs1;
    logic raw_rs2;
    logic unused_fwd;

    // Without forwarding, operands come straight from the stage register.
    always_comb begin
        fwd_rs1 = stage_q.rs1_data;
        fwd_rs2 = stage_q.rs2_data;
    end

    // Any pending write to a source register in EX, MEM or WB is a hazard.
    always_comb begin
        raw_rs1 = 1'b0;
        raw_rs2 = 1'b0;
        if (in_rs1_addr != 5'd0) begin
            raw_rs1 = (stage_q.valid && stage_q.reg_write && (stage_q.rd_addr == in_rs1_addr)) ||
                      (mem_reg_write && (mem_rd_addr == in_rs1_addr)) ||
                      (wb_reg_write && (wb_rd_addr == in_rs1_addr));
        end
        if (in_rs2_addr != 5'd0) begin
            raw_rs2 = (stage_q.valid && stage_q.reg_write && (stage_q.rd_addr == in_rs2_addr)) ||
                      (mem_reg_write && (mem_rd_addr == in_rs2_addr)) ||
                      (wb_reg_write && (wb_rd_addr == in_rs2_addr));
        end
    end

    assign load_use_hazard = load_use_raw || (in_valid && (raw_rs1 || raw_rs2));
    assign unused_fwd      = ^{mem_result, wb_result, stage_q.rs1_addr, stage_q.rs2_addr};
`endif

    assign alu_a         = fwd_rs1;
    assign ex_store_data = fwd_rs2;
    assign alu_b         = stage_q.alu_src ? stage_q.imm : fwd_rs2;
    assign alu_control   = stage_q.alu_control;
    assign ex_valid      = stage_q.valid;
    assign ex_reg_write  = stage_q.reg_write;
    assign ex_mem_read   = stage_q.mem_read;
    assign ex_mem_write  = stage_q.mem_write;
    assign ex_rd_addr    = stage_q.rd_addr;

endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: directed testbench for id_ex_stage.
// Expected values are hand-computed. They follow FORWARDING_EN when it is defined.
module tb_id_ex_stage;

    localparam int XLEN = 32;

    logic            clk;
    logic            rst_n;
    logic            stall;
    logic            flush;
    logic            in_valid;
    logic [XLEN-1:0] in_rs1_data;
    logic [XLEN-1:0] in_rs2_data;
    logic [XLEN-1:0] in_imm;
    logic [4:0]      in_rs1_addr;
    logic [4:0]      in_rs2_addr;
    logic [4:0]      in_rd_addr;
    logic            in_alu_src;
    logic [2:0]      in_alu_control;
    logic            in_reg_write;
    logic            in_mem_read;
    logic            in_mem_write;
    logic [4:0]      mem_rd_addr;
    logic [4:0]      wb_rd_addr;
    logic            mem_reg_write;
    logic            wb_reg_write;
    logic [XLEN-1:0] mem_result;
    logic [XLEN-1:0] wb_result;
    logic [XLEN-1:0] alu_a;
    logic [XLEN-1:0] alu_b;
    logic [2:0]      alu_control;
    logic            ex_valid;
    logic            ex_reg_write;
    logic            ex_mem_read;
    logic            ex_mem_write;
    logic [4:0]      ex_rd_addr;
    logic [XLEN-1:0] ex_store_data;
    logic            load_use_hazard;

    int checks   = 0;
    int failures = 0;

    id_ex_stage #(.XLEN(XLEN)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .stall           (stall),
        .flush           (flush),
        .in_valid        (in_valid),
        .in_rs1_data     (in_rs1_data),
        .in_rs2_data     (in_rs2_data),
        .in_imm          (in_imm),
        .in_rs1_addr     (in_rs1_addr),
        .in_rs2_addr     (in_rs2_addr),
        .in_rd_addr      (in_rd_addr),
        .in_alu_src      (in_alu_src),
        .in_alu_control  (in_alu_control),
        .in_reg_write    (in_reg_write),
        .in_mem_read     (in_mem_read),
        .in_mem_write    (in_mem_write),
        .mem_rd_addr     (mem_rd_addr),
        .wb_rd_addr      (wb_rd_addr),
        .mem_reg_write   (mem_reg_write),
        .wb_reg_write    (wb_reg_write),
        .mem_result      (mem_result),
        .wb_result       (wb_result),
        .alu_a           (alu_a),
        .alu_b           (alu_b),
        .alu_control     (alu_control),
        .ex_valid        (ex_valid),
        .ex_reg_write    (ex_reg_write),
        .ex_mem_read     (ex_mem_read),
        .ex_mem_write    (ex_mem_write),
        .ex_rd_addr      (ex_rd_addr),
        .ex_store_data   (ex_store_data),
        .load_use_hazard (load_use_hazard)
    );

    // Free-running 10-unit clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Watchdog so the run always ends.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Count one comparison and report it if it differs.
    task automatic checkOutput(input string tag, input logic [XLEN-1:0] actual,
                               input logic [XLEN-1:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", tag, actual, expected);
        end
    endtask

    // Drive the decode-side fields.
    task automatic applyStimulus(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                                 input logic [4:0] rd, input logic [XLEN-1:0] d1,
                                 input logic [XLEN-1:0] d2, input logic [XLEN-1:0] imm,
                                 input logic src, input logic [2:0] ctl, input logic rw,
                                 input logic mr, input logic mw);
        in_valid       = v;
        in_rs1_addr    = rs1;
        in_rs2_addr    = rs2;
        in_rd_addr     = rd;
        in_rs1_data    = d1;
        in_rs2_data    = d2;
        in_imm         = imm;
        in_alu_src     = src;
        in_alu_control = ctl;
        in_reg_write   = rw;
        in_mem_read    = mr;
        in_mem_write   = mw;
    endtask

    // Drive the MEM and WB bypass sources.
    task automatic applyBypass(input logic [4:0] mrd, input logic mwe, input logic [XLEN-1:0] mres,
                               input logic [4:0] wrd, input logic wwe, input logic [XLEN-1:0] wres);
        mem_rd_addr   = mrd;
        mem_reg_write = mwe;
        mem_result    = mres;
        wb_rd_addr    = wrd;
        wb_reg_write  = wwe;
        wb_result     = wres;
    endtask

    // Advance past the next rising edge and let outputs settle.
    task automatic stepClock();
        @(posedge clk);
        #1;
    endtask

    // Check that every output is at its bubble/reset value.
    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_alu_a"}, alu_a, '0);
        checkOutput({tag, "_alu_b"}, alu_b, '0);
        checkOutput({tag, "_store"}, ex_store_data, '0);
        checkOutput({tag, "_ctl"}, {29'd0, alu_control}, '0);
        checkOutput({tag, "_ctrl_bits"},
                    {28'd0, ex_valid, ex_reg_write, ex_mem_read, ex_mem_write}, '0);
        checkOutput({tag, "_rd"}, {27'd0, ex_rd_addr}, '0);
        checkOutput({tag, "_hazard"}, {31'd0, load_use_hazard}, '0);
    endtask

    // Directed sequence.
    initial begin
        rst_n = 1'b0;
        stall = 1'b0;
        flush = 1'b0;
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 3'd0, 0, 0, 0);
        applyBypass(0, 0, 0, 0, 0, 0);

        // Reset, then three idle cycles.
        stepClock();
        stepClock();
        checkAllZero("reset");
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            stepClock();
            checkAllZero("idle");
        end

        // Forwarding priority with ADD x3,x1,x2.
        applyStimulus(1, 5'd1, 5'd2, 5'd3, 32'd5, 32'd7, 0, 0, 3'b000, 1, 0, 0);
        stepClock();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 3'd0, 0, 0, 0);
        applyBypass(5'd1, 1, 32'd100, 5'd1, 1, 32'd200);
        #1;
        checkOutput("add_valid", {31'd0, ex_valid}, 32'd1);
        checkOutput("add_rd", {27'd0, ex_rd_addr}, 32'd3);
`ifdef FORWARDING_EN
        checkOutput("fwd_mem_prio", alu_a, 32'd100);
`else
        checkOutput("nofwd_a", alu_a, 32'd5);
`endif
        checkOutput("add_alu_b", alu_b, 32'd7);
        mem_reg_write = 1'b0;
        #1;
`ifdef FORWARDING_EN
        checkOutput("fwd_wb", alu_a, 32'd200);
`else
        checkOutput("nofwd_a_wb", alu_a, 32'd5);
`endif
        wb_rd_addr = 5'd2;
        #1;
`ifdef FORWARDING_EN
        checkOutput("fwd_wb_rs2", ex_store_data, 32'd200);
        checkOutput("fwd_wb_rs2_b", alu_b, 32'd200);
`else
        checkOutput("nofwd_rs2", ex_store_data, 32'd7);
        checkOutput("nofwd_rs2_b", alu_b, 32'd7);
`endif

        // ADDI with rs1 = x0 and imm = -4. x0 must not be forwarded.
        applyBypass(0, 0, 0, 0, 0, 0);
        applyStimulus(1, 5'd0, 5'd0, 5'd4, 32'd0, 32'd0, 32'hFFFF_FFFC, 1, 3'b000, 1, 0, 0);
        stepClock();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 3'd0, 0, 0, 0);
        applyBypass(5'd0, 1, 32'd55, 5'd0, 1, 32'd66);
        #1;
        checkOutput("x0_alu_a", alu_a, 32'd0);
        checkOutput("imm_alu_b", alu_b, 32'hFFFF_FFFC);
        checkOutput("x0_store", ex_store_data, 32'd0);

        // LW x5 followed by SUB x6,x5,x1.
        applyBypass(0, 0, 0, 0, 0, 0);
        applyStimulus(1, 5'd2, 5'd0, 5'd5, 32'd40, 32'd0, 32'd8, 1, 3'b000, 1, 1, 0);
        stepClock();
        checkOutput("lw_mem_read", {31'd0, ex_mem_read}, 32'd1);
        checkOutput("lw_alu_b", alu_b, 32'd8);
        applyStimulus(1, 5'd5, 5'd1, 5'd6, 32'd11, 32'd3, 32'd0, 0, 3'b001, 1, 0, 0);
        #1;
        checkOutput("lu_hazard", {31'd0, load_use_hazard}, 32'd1);
        stepClock();
        checkOutput("lu_bubble", {31'd0, ex_valid}, 32'd0);
        applyBypass(5'd5, 1, 32'd77, 5'd0, 0, 0);
        #1;
`ifdef FORWARDING_EN
        checkOutput("lu_clear", {31'd0, load_use_hazard}, 32'd0);
        stepClock();
`else
        checkOutput("raw_mem", {31'd0, load_use_hazard}, 32'd1);
        stepClock();
        checkOutput("raw_mem_bubble", {31'd0, ex_valid}, 32'd0);
        applyBypass(5'd0, 0, 0, 5'd5, 1, 32'd77);
        #1;
        checkOutput("raw_wb", {31'd0, load_use_hazard}, 32'd1);
        stepClock();
        checkOutput("raw_wb_bubble", {31'd0, ex_valid}, 32'd0);
        applyBypass(5'd5, 1, 32'd77, 5'd0, 0, 0);
        mem_reg_write = 1'b0;
        #1;
        checkOutput("raw_clear", {31'd0, load_use_hazard}, 32'd0);
        stepClock();
        mem_reg_write = 1'b1;
`endif
        #1;
        checkOutput("sub_valid", {31'd0, ex_valid}, 32'd1);
        checkOutput("sub_ctl", {29'd0, alu_control}, 32'd1);
`ifdef FORWARDING_EN
        checkOutput("sub_fwd_a", alu_a, 32'd77);
`else
        checkOutput("sub_reg_a", alu_a, 32'd11);
`endif
        checkOutput("sub_alu_b", alu_b, 32'd3);

        // Stall for two cycles while decode keeps changing.
        applyBypass(0, 0, 0, 0, 0, 0);
        stall = 1'b1;
        applyStimulus(1, 5'd9, 5'd10, 5'd9, 32'd999, 32'd888, 32'd1, 1, 3'b010, 0, 1, 1);
        stepClock();
        applyStimulus(1, 5'd12, 5'd13, 5'd14, 32'd321, 32'd654, 32'd2, 0, 3'b100, 1, 0, 1);
        stepClock();
        checkOutput("stall_rd", {27'd0, ex_rd_addr}, 32'd6);
        checkOutput("stall_ctl", {29'd0, alu_control}, 32'd1);
        checkOutput("stall_alu_a", alu_a, 32'd11);
        checkOutput("stall_ctrl_bits",
                    {28'd0, ex_valid, ex_reg_write, ex_mem_read, ex_mem_write}, 32'b1100);

        // Flush together with stall loads a bubble.
        flush = 1'b1;
        stepClock();
        checkOutput("flush_valid", {31'd0, ex_valid}, 32'd0);
        checkOutput("flush_reg_write", {31'd0, ex_reg_write}, 32'd0);
        flush = 1'b0;
        stall = 1'b0;

        // Reset between clock edges while a valid instruction sits in EX.
        applyStimulus(1, 5'd9, 5'd10, 5'd7, 32'd123, 32'd456, 32'd0, 0, 3'b011, 1, 0, 0);
        stepClock();
        checkOutput("pre_reset_valid", {31'd0, ex_valid}, 32'd1);
        checkOutput("pre_reset_a", alu_a, 32'd123);
        #2;
        rst_n = 1'b0;
        stall = 1'b1;
        #1;
        checkAllZero("async_reset");
        stepClock();
        checkAllZero("reset_stall");
        stall = 1'b0;
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 3'd0, 0, 0, 0);
        rst_n = 1'b1;
        stepClock();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

ID/EX pipeline stage of the 32-bit RISC-V core, sitting directly upstream of the ALU. It registers decoded operands and control from decode, applies MEM→EX and WB→EX operand forwarding, and selects register or immediate for operand B. It drives the ALU's A, B and ALUControl inputs. It also detects load-use hazards and inserts a bubble when one occurs.

## Interface
Parameters:
- XLEN, 32, datapath width.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset: asynchronous, active-low.
- stall  in  1  hold the stage register; a downstream stall.
- flush  in  1  load a bubble; branch or jump redirect.
- in_valid  in  1  decode slot holds a real instruction.
- in_rs1_data, in_rs2_data  in  XLEN  register-file read data.
- in_imm  in  XLEN  sign-extended immediate.
- in_rs1_addr, in_rs2_addr, in_rd_addr  in  5  register indices.
- in_alu_src  in  1  1 = operand B is the immediate.
- in_alu_control  in  3  ALU operation code: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SLL, 110 SRL, 111 SLT.
- in_reg_write, in_mem_read, in_mem_write  in  1  decoded control bits.
- mem_rd_addr, wb_rd_addr  in  5  destination registers in MEM and WB.
- mem_reg_write, wb_reg_write  in  1  write enables in MEM and WB.
- mem_result, wb_result  in  XLEN  forwarding data.
- alu_a, alu_b  out  XLEN  ALU operands.
- alu_control  out  3  ALU operation.
- ex_valid, ex_reg_write, ex_mem_read, ex_mem_write  out  1  registered control bits.
- ex_rd_addr  out  5  registered destination register.
- ex_store_data  out  XLEN  forwarded rs2 value, for stores.
- load_use_hazard  out  1  combinational request to stall IF/ID.

## Operation
- The stage register holds every in_* field. Update priority per clock edge:
  - flush: load a bubble.
  - otherwise stall: hold all fields.
  - otherwise load_use_hazard: load a bubble.
  - otherwise capture the in_* fields.
- Bubble contents: valid, reg_write, mem_read and mem_write all 0; alu_control 000; rd, rs and data fields all 0.
- When in_valid is 0, the captured fields are gated to bubble values.
- Forwarding for operand A (rs1) and for rs2, evaluated independently:
  - MEM hit: mem_reg_write && mem_rd_addr != 0 && mem_rd_addr == ex_rsN → use mem_result.
  - WB hit: otherwise wb_reg_write && wb_rd_addr != 0 && wb_rd_addr == ex_rsN → use wb_result.
  - No hit: use the registered rsN data.
  - MEM has priority over WB when both hit.
- Operand outputs:
  - alu_a = forwarded rs1.
  - ex_store_data = forwarded rs2.
  - alu_b = registered immediate if alu_src = 1, else forwarded rs2.
- Register x0 is never forwarded, and its registered data passes through unchanged.
- load_use_hazard = ex_valid && ex_mem_read && ex_rd_addr != 0 && in_valid && (ex_rd_addr == in_rs1_addr || ex_rd_addr == in_rs2_addr).
  - The check is conservative: it does not depend on whether the instruction actually uses rs2.
- Exactly one bubble is inserted per load-use hazard. On the next cycle the hazard clears, and the held decode instruction is captured with WB or MEM forwarding.

## Timing
- Reset: while rst_n = 0 the register is asynchronously cleared to bubble values.
  - All outputs are therefore 0 during reset: alu_a, alu_b, ex_store_data, alu_control (000), ex_* and load_use_hazard.
- Register latency: 1 cycle from in_* to the ex_* and alu_* outputs.
- Forwarding and the alu_b mux are combinational from the current mem_* and wb_* inputs, with zero latency.
- load_use_hazard is combinational from the in_* inputs and the registered state, with no register stage.
- Simultaneous events:
  - flush with stall: the bubble is loaded.
  - stall with load_use_hazard: hold. The hazard remains visible and is re-evaluated on the next cycle.
- Reset asserted mid-stall clears immediately; stall has no effect until rst_n deasserts.
- Arithmetic: no width changes; all datapaths are XLEN.

## Configuration
- FORWARDING_EN defined: forwarding behaves as described in Operation.
- FORWARDING_EN undefined: no forwarding is performed.
  - alu_a and ex_store_data are the registered rs1 and rs2 data.
  - load_use_hazard widens to any RAW dependency: in_rs1_addr or in_rs2_addr (nonzero) matching a valid, reg-writing ex_rd_addr or mem_rd_addr, or wb_rd_addr with wb_reg_write.
  - One bubble is inserted per hazard cycle.

## Test plan
- Reset then release with in_valid = 0: all outputs are 0 and alu_control = 000 for 3 cycles.
- Forwarding priority: capture ADD x3,x1,x2 (rs1 = 5, rs2 = 7) with mem_rd = 1 / mem_result = 100 and wb_rd = 1 / wb_result = 200.
  - Required: alu_a = 100, alu_b = 7.
  - Then mem_reg_write = 0: alu_a = 200.
- Immediate and x0: ADDI, rs1 = x0, imm = -4, mem_rd = 0, mem_reg_write = 1, mem_result = 55.
  - Required: alu_a = 0, alu_b = 0xFFFFFFFC.
- Load-use: LW x5 captured, then decode presents SUB x6,x5,x1.
  - Required: load_use_hazard = 1 for one cycle and a bubble is loaded (ex_valid = 0).
  - Next cycle: SUB is captured with alu_control = 001 and alu_a forwarded from mem_result.
- Stall and flush:
  - stall = 1 for 2 cycles with changing in_*: outputs are held.
  - flush = 1 together with stall = 1: ex_valid = 0 and ex_reg_write = 0 after the edge.
- Reset mid-operation: assert rst_n = 0 between clock edges while ex_valid = 1. All outputs drop to 0 immediately, without waiting for a clock edge.
